// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_t : controller states (IDLE, CHECK, ITER, FIXUP, DONE)
//   - clog2       : bit-counter width helper (never returns less than 1)
//   - DIV0_FILL_BIT : fill bit replicated across the quotient on divide-by-zero
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ITER,
    FIXUP,
    DONE
  } div_state_t;

  // Divide-by-zero reports an all-ones quotient.
  localparam logic DIV0_FILL_BIT = 1'b1;

  // Number of bits needed to count 0..value-1, minimum 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step
// One restoring-division step: shift the partial remainder left, bring in
// the next dividend bit, trial-subtract the divisor and keep or restore.
// Ports:
//   rem_i     - partial remainder before the step (WIDTH+1 bits)
//   bit_i     - next dividend bit, MSB first
//   divisor_i - divisor magnitude
//   rem_o     - partial remainder after the step
//   qbit_o    - quotient bit produced by this step
module div_restore_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);
  import div_pkg::*;

  logic [WIDTH+1:0] shiftedWide;
  logic [WIDTH+1:0] trialDiff;

  // The subtraction runs one bit wider than the partial remainder so its
  // MSB is a clean borrow: set means the trial went negative and the
  // shifted value must be restored.
  always_comb begin
    shiftedWide = {rem_i, bit_i};
    trialDiff   = shiftedWide - {2'b00, divisor_i};
    qbit_o      = ~trialDiff[WIDTH+1];
    rem_o       = qbit_o ? trialDiff[WIDTH:0] : shiftedWide[WIDTH:0];
  end

endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit
// Self-timed restoring integer divider, one quotient bit per clock.
// Signed operands are reduced to magnitudes on accept and the signs are
// reapplied in FIXUP (truncation toward zero, remainder follows dividend).
// Ports:
//   clock, reset_n       - clock and asynchronous active-low reset
//   start                - request, honoured only in IDLE
//   is_signed            - two's complement operands (if SIGNED_EN != 0)
//   dividend, divisor    - operands, sampled on the accepting edge
//   busy                 - high whenever the unit is not IDLE
//   done                 - one-cycle pulse, results valid
//   error                - divide-by-zero flag, held until next accept
//   quotient, remainder  - results, held until next accept
module div_seq_unit #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  import div_pkg::*;

  localparam int CW = clog2(WIDTH);

  div_state_t       state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   prem_q;
  logic [CW-1:0]    cnt_q;
  logic             signQ_q;
  logic             signR_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;

  logic             signedMode;
  logic             dvdNeg;
  logic             dsrNeg;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] dsr_d;
  logic [WIDTH-1:0] quoFix;
  logic [WIDTH-1:0] remFix;
  logic [WIDTH-1:0] div0Rem;
  logic [WIDTH:0]   stepRem;
  logic             stepBit;

  // Operand magnitudes for capture, and sign-corrected results for
  // FIXUP/CHECK. The most-negative value negates to itself, which as an
  // unsigned magnitude is exactly right, so no special case is needed.
  // Negating the captured magnitude by sign_r also recovers the original
  // dividend for the divide-by-zero remainder.
  always_comb begin
    signedMode = is_signed && (SIGNED_EN != 0);
    dvdNeg     = signedMode && dividend[WIDTH-1];
    dsrNeg     = signedMode && divisor[WIDTH-1];
    dvd_d      = dvdNeg ? -dividend : dividend;
    dsr_d      = dsrNeg ? -divisor : divisor;
    quoFix     = signQ_q ? -dvd_q : dvd_q;
    remFix     = signR_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
    div0Rem    = signR_q ? -dvd_q : dvd_q;
  end

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (prem_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .divisor_i(dsr_q),
    .rem_o    (stepRem),
    .qbit_o   (stepBit)
  );

  // Controller and datapath. dvd_q doubles as the quotient shift register:
  // dividend bits leave at the top while quotient bits enter at the bottom,
  // so after WIDTH steps it holds the unsigned quotient.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      signQ_q <= 1'b0;
      signR_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            signQ_q <= dvdNeg ^ dsrNeg;
            signR_q <= dvdNeg;
            err_q   <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (dsr_q == '0) begin
            err_q   <= 1'b1;
            quo_q   <= {WIDTH{DIV0_FILL_BIT}};
            rmd_q   <= div0Rem;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            prem_q  <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            state_q <= ITER;
          end
        end
        ITER: begin
          prem_q <= stepRem;
          dvd_q  <= {dvd_q[WIDTH-2:0], stepBit};
          if (cnt_q == '0) begin
            state_q <= FIXUP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        FIXUP: begin
          quo_q   <= quoFix;
          rmd_q   <= remFix;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign error     = err_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit
// Directed bench for div_seq_unit: an 8-bit signed-capable instance driven
// from a vector table plus hand-written multi-cycle sequences, and a 16-bit
// unsigned-only instance for the forced-unsigned case.
module tb_div_seq_unit;

  localparam int BUDGET = 40;

  typedef struct {
    string      name;
    logic       sgn;
    logic [7:0] dvd;
    logic [7:0] dsr;
    logic [7:0] expQ;
    logic [7:0] expR;
    logic       expErr;
    int         expLat;
  } vec_t;

  logic clock;
  logic reset_n;

  logic        start8, isSigned8, busy8, done8, error8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        start16, isSigned16, busy16, done16, error16;
  logic [15:0] dividend16, divisor16, quotient16, remainder16;

  int checks;
  int errors;

  vec_t vecs[13];

  div_seq_unit #(.WIDTH(8), .SIGNED_EN(1)) dut8 (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start8),
    .is_signed(isSigned8),
    .dividend (dividend8),
    .divisor  (divisor8),
    .busy     (busy8),
    .done     (done8),
    .error    (error8),
    .quotient (quotient8),
    .remainder(remainder8)
  );

  div_seq_unit #(.WIDTH(16), .SIGNED_EN(0)) dut16 (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start16),
    .is_signed(isSigned16),
    .dividend (dividend16),
    .divisor  (divisor16),
    .busy     (busy16),
    .done     (done16),
    .error    (error16),
    .quotient (quotient16),
    .remainder(remainder16)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something above escapes its own cycle budget.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic curBusy(input bit wide);
    return wide ? busy16 : busy8;
  endfunction

  function automatic logic curDone(input bit wide);
    return wide ? done16 : done8;
  endfunction

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Present a request, let the next rising edge accept it, then drop start
  // and scramble the operands to show they are only sampled on accept.
  task automatic applyStimulus(input bit wide, input logic sgn,
                               input logic [15:0] dvd, input logic [15:0] dsr);
    @(negedge clock);
    if (wide) begin
      start16 = 1'b1; isSigned16 = sgn; dividend16 = dvd; divisor16 = dsr;
    end else begin
      start8 = 1'b1; isSigned8 = sgn; dividend8 = dvd[7:0]; divisor8 = dsr[7:0];
    end
    @(posedge clock);
    #1;
    start8     = 1'b0;
    start16    = 1'b0;
    dividend8  = 8'($urandom);
    divisor8   = 8'($urandom);
    dividend16 = 16'($urandom);
    divisor16  = 16'($urandom);
  endtask

  // Called 1 time unit after the accepting edge (cycle 1). Walks forward
  // until done, checking busy stays high and that done lands on expLat.
  task automatic waitDone(input bit wide, input int expLat, input string name);
    int  c;
    bit  seen;
    bit  busyOk;
    c      = 1;
    seen   = 1'b0;
    busyOk = 1'b1;
    while (c <= BUDGET) begin
      if (!curBusy(wide)) busyOk = 1'b0;
      if (curDone(wide)) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      c++;
    end
    checkOutput({name, ".latency"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(expLat));
    checkOutput({name, ".busy"}, 32'(busyOk), 32'd1);
  endtask

  // Result checks in the done cycle, then one cycle later: pulse gone,
  // unit idle, results still held.
  task automatic checkResult(input bit wide, input string name,
                             input logic [15:0] expQ, input logic [15:0] expR,
                             input logic expErr);
    logic [15:0] q, r;
    q = wide ? quotient16 : {8'h00, quotient8};
    r = wide ? remainder16 : {8'h00, remainder8};
    checkOutput({name, ".quotient"}, 32'(q), 32'(expQ));
    checkOutput({name, ".remainder"}, 32'(r), 32'(expR));
    checkOutput({name, ".error"}, 32'(wide ? error16 : error8), 32'(expErr));
    @(posedge clock);
    #1;
    q = wide ? quotient16 : {8'h00, quotient8};
    checkOutput({name, ".afterDone"},
                {14'h0, curDone(wide), curBusy(wide), q}, {16'h0, expQ});
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(1'b0, v.sgn, {8'h00, v.dvd}, {8'h00, v.dsr});
    waitDone(1'b0, v.expLat, v.name);
    checkResult(1'b0, v.name, {8'h00, v.expQ}, {8'h00, v.expR}, v.expErr);
  endtask

  initial begin
    int  c;
    bit  sawDone;

    checks = 0;
    errors = 0;

    //           name         sgn   dvd    dsr    expQ   expR  err  lat
    vecs[0]  = '{"u200_7",    1'b0, 8'd200, 8'd7,  8'h1C, 8'h04, 1'b0, 11};
    vecs[1]  = '{"sM100_7",   1'b1, 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 11};
    vecs[2]  = '{"s100_M7",   1'b1, 8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 11};
    vecs[3]  = '{"u55_0",     1'b0, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 2};
    vecs[4]  = '{"u9_3",      1'b0, 8'd9,  8'd3,  8'h03, 8'h00, 1'b0, 11};
    vecs[5]  = '{"sM128_M1",  1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 11};
    vecs[6]  = '{"u5_9",      1'b0, 8'd5,  8'd9,  8'h00, 8'h05, 1'b0, 11};
    vecs[7]  = '{"u255_1",    1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 11};
    vecs[8]  = '{"s7_M2",     1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 11};
    vecs[9]  = '{"sM7_2",     1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 11};
    vecs[10] = '{"u156_7",    1'b0, 8'h9C, 8'h07, 8'h16, 8'h02, 1'b0, 11};
    vecs[11] = '{"sM3_0",     1'b1, 8'hFD, 8'h00, 8'hFF, 8'hFD, 1'b1, 2};
    vecs[12] = '{"u255_255",  1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 11};

    reset_n    = 1'b0;
    start8     = 1'b0; isSigned8  = 1'b0; dividend8  = '0; divisor8  = '0;
    start16    = 1'b0; isSigned16 = 1'b0; dividend16 = '0; divisor16 = '0;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset.outputs8",
                {19'h0, busy8, done8, error8, quotient8, remainder8}, 32'h0);
    checkOutput("reset.outputs16", {29'h0, busy16, done16, error16}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven vectors on the 8-bit instance.
    for (int i = 0; i < 13; i++) begin
      runVector(vecs[i]);
    end

    // start held high across a whole operation with new operands: the
    // in-flight result is unaffected, DONE ignores start, and the request
    // is taken on the following IDLE cycle.
    @(negedge clock);
    start8 = 1'b1; isSigned8 = 1'b0; dividend8 = 8'd200; divisor8 = 8'd7;
    @(posedge clock);
    #1;
    dividend8 = 8'd9; divisor8 = 8'd3;
    waitDone(1'b0, 11, "hold.first");
    checkOutput("hold.firstQuotient", 32'(quotient8), 32'h1C);
    checkOutput("hold.firstRemainder", 32'(remainder8), 32'h04);
    @(posedge clock);
    #1;
    checkOutput("hold.idleAfterDone", 32'(busy8), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("hold.acceptedNext", 32'(busy8), 32'd1);
    start8 = 1'b0;
    waitDone(1'b0, 11, "hold.second");
    checkResult(1'b0, "hold.second", 16'h0003, 16'h0000, 1'b0);

    // Asynchronous reset mid-ITER: outputs clear without waiting for an
    // edge and the abandoned operation never pulses done.
    applyStimulus(1'b0, 1'b0, 16'd200, 16'd7);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.outputs",
                {19'h0, busy8, done8, error8, quotient8, remainder8}, 32'h0);
    sawDone = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
      if (done8) sawDone = 1'b1;
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock);
      #1;
      if (done8 || busy8) sawDone = 1'b1;
    end
    checkOutput("midReset.noDone", 32'(sawDone), 32'd0);
    runVector('{"midReset.u9_3", 1'b0, 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 11});

    // 16-bit instance built without signed support: is_signed is ignored.
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'h0002);
    waitDone(1'b1, 19, "w16.ffff_2");
    checkResult(1'b1, "w16.ffff_2", 16'h7FFF, 16'h0001, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h8000, 16'hFFFF);
    waitDone(1'b1, 19, "w16.8000_ffff");
    checkResult(1'b1, "w16.8000_ffff", 16'h0000, 16'h8000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
